fetch_unit: RTL and testbench

Parametrised, latency-tolerant instruction fetch stage for the pipelined RV32I core. It replaces the single-cycle PC and instruction-memory pairing. It keeps up to DEPTH requests in flight to a valid/ready instruction memory with in-order responses, and buffers returned instructions with their PCs. It hands them to decode over a valid/ready interface, and supports branch redirect with discard of stale in-flight responses.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_buf.sv | 94 +++++++++
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_buf.sv
// Fetch buffer: in-order entries {pc, inst, filled} allocated on request accept,
// filled by in-order responses and released from the head, with single-cycle flush.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   alloc,
    input  logic [XLEN-1:0]        alloc_pc,
    input  logic                   fill,
    input  logic [XLEN-1:0]        fill_inst,
    input  logic                   deq,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output logic [XLEN-1:0]        head_pc,
    output logic [XLEN-1:0]        head_inst
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [XLEN-1:0]  pc_d   [DEPTH];
    logic [XLEN-1:0]  inst_q [DEPTH];
    logic [XLEN-1:0]  inst_d [DEPTH];

    // Alloc, fill and dequeue always target distinct slots, so all three may apply together.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        filled_d   = filled_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        count_d    = count_q + CW'(alloc) - CW'(deq);

        if (alloc) begin
            pc_d[wr_ptr_q]     = alloc_pc;
            filled_d[wr_ptr_q] = 1'b0;
            wr_ptr_d           = wr_ptr_q + PW'(1);
        end
        if (fill) begin
            inst_d[fill_ptr_q]   = fill_inst;
            filled_d[fill_ptr_q] = 1'b1;
            fill_ptr_d           = fill_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (flush) begin
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            filled_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            filled_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            filled_q   <= filled_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0) && filled_q[rd_ptr_q];
    assign head_pc    = head_valid ? pc_q[rd_ptr_q] : '0;
    assign head_inst  = head_valid ? inst_q[rd_ptr_q] : XLEN'(NOP_INST);

endmodule

// File: rtl/fetch_unit.sv
// Latency-tolerant fetch stage: issues up to DEPTH in-order requests, buffers
// responses for decode, and discards stale responses after a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(DEPTH) + 2;

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic            started_q, started_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count;
    logic            accept, rsp_ok, rsp_drop, fill, deq;

    assign imem_req_valid = started_q && !redirect_valid && (count < CW'(DEPTH));
    assign imem_req_addr  = fpc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_drop       = rsp_ok && (drop_cnt_q != '0);
    assign fill           = rsp_ok && !rsp_drop && !redirect_valid;
    assign deq            = out_valid && out_ready;

    always_comb begin
        started_d     = started_q | start;
        fpc_d         = accept ? fpc_q + XLEN'(INST_BYTES) : fpc_q;
        outstanding_d = outstanding_q + OW'(accept) - OW'(rsp_ok);
        drop_cnt_d    = drop_cnt_q - OW'(rsp_drop);
        // Everything still in flight becomes stale, except a response consumed this cycle.
        if (redirect_valid) begin
            fpc_d      = redirect_pc;
            drop_cnt_d = outstanding_q - OW'(rsp_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            started_q     <= 1'b0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fpc_q         <= fpc_d;
            started_q     <= started_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_buf #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .alloc      (accept),
        .alloc_pc   (fpc_q),
        .fill       (fill),
        .fill_inst  (imem_rsp_data),
        .deq        (deq),
        .count      (count),
        .head_valid (out_valid),
        .head_pc    (out_pc),
        .head_inst  (out_inst)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model returning addr+0x100, and a
// program-order reference of the PC stream that decode must see.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] OFS      = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst, start, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst;

    fetch_unit #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; int unsigned max_wait; } vec_t;

    mreq_t       mq[$];
    vec_t        tbl [6];
    int unsigned cyc, lat, last_due, acc_cnt;
    bit          lat_rand, rdy_rand, dlv, last_rsp;
    logic [31:0] dlv_pc, dlv_inst;
    int          vectors, miscompares;

    // Reference: next fetch address, next PC decode must receive, live entry count.
    logic [31:0] m_fpc, m_exp_pc;
    bit          m_started;
    int unsigned m_live;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_pc"}, out_pc, 32'd0);
        check({tag, "_out_inst"}, out_inst, NOP);
    endtask

    // One clock: drive memory, check outputs, advance models; starts and ends at negedge.
    task automatic step();
        bit          acc, exp_rv;
        int unsigned due;
        mreq_t       r;
        imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        imem_rsp_valid = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_data  = imem_rsp_valid ? mq[0].addr + OFS : $urandom;
        #1;
        exp_rv = m_started && !redirect_valid && (m_live < DEPTH);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (imem_req_valid) check("req_addr", imem_req_addr, m_fpc);
        if (!out_valid) begin
            check("idle_pc", out_pc, 32'd0);
            check("idle_inst", out_inst, NOP);
        end
        dlv      = out_valid && out_ready;
        last_rsp = imem_rsp_valid;
        if (dlv) begin
            dlv_pc   = out_pc;
            dlv_inst = out_inst;
            check("out_pc", out_pc, m_exp_pc);
            check("out_inst", out_inst, m_exp_pc + OFS);
        end
        acc = imem_req_valid && imem_req_ready;
        if (imem_rsp_valid) void'(mq.pop_front());
        if (acc) begin
            if (lat_rand) lat = $urandom_range(1, 3);
            due = cyc + lat;
            if (due < last_due) due = last_due;
            last_due = due;
            r.addr = imem_req_addr;
            r.due  = due;
            mq.push_back(r);
            acc_cnt++;
        end
        if (rst) begin
            m_fpc = RESET_PC; m_exp_pc = RESET_PC; m_started = 1'b0; m_live = 0;
        end else if (redirect_valid) begin
            m_fpc = redirect_pc; m_exp_pc = redirect_pc; m_live = 0;
            m_started = m_started | start;
        end else begin
            if (acc) begin m_fpc = m_fpc + 32'd4; m_live++; end
            if (dlv) begin m_exp_pc = m_exp_pc + 32'd4; m_live--; end
            m_started = m_started | start;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic expect_dlv(input string name, input logic [31:0] pc, input logic [31:0] inst,
                              input int unsigned max_wait);
        int unsigned n = 0;
        dlv = 1'b0;
        while (!dlv && n < max_wait) begin
            step();
            n++;
        end
        check({name, "_seen"}, 32'(dlv), 32'd1);
        if (dlv) begin
            check({name, "_pc"}, dlv_pc, pc);
            check({name, "_inst"}, dlv_inst, inst);
        end
    endtask

    initial begin
        int unsigned n;
        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        lat = 1; lat_rand = 1'b0; rdy_rand = 1'b0; last_due = 0; cyc = 0; acc_cnt = 0;
        vectors = 0; miscompares = 0;
        m_fpc = RESET_PC; m_exp_pc = RESET_PC; m_started = 1'b0; m_live = 0;

        tbl[0] = '{32'hFFFF_FFF8, 32'h0000_00F8, 4};
        tbl[1] = '{32'hFFFF_FFFC, 32'h0000_00FC, 1};
        tbl[2] = '{32'h0000_0000, 32'h0000_0100, 1};
        tbl[3] = '{32'h0000_0004, 32'h0000_0104, 1};
        tbl[4] = '{32'h0000_0008, 32'h0000_0108, 1};
        tbl[5] = '{32'h0000_000C, 32'h0000_010C, 1};

        @(negedge clk);
        step(); step();
        check_reset("reset");
        rst = 1'b0;
        step(); step();

        // Back-to-back stream through the address wrap, one instruction per cycle.
        start = 1'b1;
        for (int i = 0; i < 6; i++) expect_dlv("stream", tbl[i].pc, tbl[i].inst, tbl[i].max_wait);

        // Decode stalled: the buffer fills to DEPTH and issue stops.
        out_ready = 1'b0; redirect_pc = 32'h0; redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0; acc_cnt = 0;
        repeat (10) step();
        check("stall_accepts", acc_cnt, 32'd4);
        check("full_req_low", 32'(imem_req_valid), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) expect_dlv("stall_release", 32'(i * 4), 32'(i * 4) + OFS, 2);

        // Redirect with three responses in flight at latency 3.
        lat = 3; n = 0;
        while (mq.size() < 3 && n < 20) begin step(); n++; end
        check("lat3_inflight", 32'(mq.size()), 32'd3);
        redirect_pc = 32'h200; redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        expect_dlv("redir_200", 32'h200, 32'h300, 10);
        expect_dlv("redir_204", 32'h204, 32'h304, 3);

        // Redirect coinciding with a response and an out handshake.
        lat = 1;
        repeat (10) step();
        redirect_pc = 32'h300; redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("redir_rsp_hs", 32'(last_rsp && dlv), 32'd1);
        #1;
        check("redir_next_req", 32'(imem_req_valid), 32'd1);
        check("redir_next_addr", imem_req_addr, 32'h300);
        expect_dlv("redir_300", 32'h300, 32'h400, 4);

        // Random memory ready and latency from RESET_PC across the wrap, then a soak.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0; rdy_rand = 1'b1; lat_rand = 1'b1;
        expect_dlv("wrap0", 32'hFFFF_FFF8, 32'h0000_00F8, 30);
        expect_dlv("wrap1", 32'hFFFF_FFFC, 32'h0000_00FC, 30);
        expect_dlv("wrap2", 32'h0000_0000, 32'h0000_0100, 30);
        expect_dlv("wrap3", 32'h0000_0004, 32'h0000_0104, 30);
        repeat (400) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            step();
        end
        redirect_valid = 1'b0;

        // Reset mid-flight: late responses must never surface.
        rdy_rand = 1'b0; lat_rand = 1'b0; lat = 3; out_ready = 1'b1; n = 0;
        while (mq.size() < 2 && n < 20) begin step(); n++; end
        check("rst_inflight", 32'(mq.size() >= 2), 32'd1);
        rst = 1'b1; start = 1'b0;
        step();
        check_reset("midrst");
        rst = 1'b0;
        repeat (6) begin
            step();
            check("post_rst_out_valid", 32'(out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
